// File: rtl/pwm_duty_decoder.sv
// Recovers the 8-bit duty of three independent PWM lines by measuring the
// rise-to-rise period and the high time inside it.
module pwm_duty_decoder #(
    parameter int PERIOD = 256,
    parameter int TOL    = 4,
    parameter int CNT_W  = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pwm_r,
    input  logic       pwm_g,
    input  logic       pwm_b,
    output logic [7:0] duty_r,
    output logic [7:0] duty_g,
    output logic [7:0] duty_b,
    output logic       valid_r,
    output logic       valid_g,
    output logic       valid_b,
    output logic       err_r,
    output logic       err_g,
    output logic       err_b
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(PERIOD - TOL);
    localparam logic [CNT_W-1:0] MAX_P = CNT_W'(PERIOD + TOL);

    typedef enum logic {IDLE, MEASURE} state_t;

    function automatic logic [7:0] sat8(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(255)) ? 8'hFF : v[7:0];
    endfunction

    logic [2:0] line;
    assign line = {pwm_b, pwm_g, pwm_r};

    for (genvar ch = 0; ch < 3; ch++) begin : g_ch
        logic             line_p0, line_p1, line_p2;
        logic             rise;
        state_t           state;
        logic [CNT_W-1:0] period_cnt;
        logic [CNT_W-1:0] high_cnt;
        logic [7:0]       duty_q;
        logic             valid_q;
        logic             err_q;

        // line_p1 is the synchronized level, line_p2 its one-cycle-old copy
        assign rise = line_p1 & ~line_p2;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                line_p0    <= 1'b0;
                line_p1    <= 1'b0;
                line_p2    <= 1'b0;
                state      <= IDLE;
                period_cnt <= '0;
                high_cnt   <= '0;
                duty_q     <= 8'h00;
                valid_q    <= 1'b0;
                err_q      <= 1'b0;
            end else begin
                line_p0 <= line[ch];
                line_p1 <= line_p0;
                line_p2 <= line_p1;
                valid_q <= 1'b0;
                err_q   <= 1'b0;
                if (rise) begin
                    period_cnt <= CNT_W'(1);
                    high_cnt   <= CNT_W'(1);
                    state      <= MEASURE;
                    if (state == MEASURE) begin
                        if (period_cnt < MIN_P) begin
                            err_q <= 1'b1;
                        end else if (period_cnt <= MAX_P) begin
                            duty_q  <= sat8(high_cnt);
                            valid_q <= 1'b1;
                        end
                    end
                end else if (period_cnt == MAX_P) begin
                    // steady line: report 0% or 100% and wait for a fresh reference edge
                    duty_q     <= {8{line_p1}};
                    valid_q    <= 1'b1;
                    period_cnt <= '0;
                    high_cnt   <= '0;
                    state      <= IDLE;
                end else begin
                    period_cnt <= period_cnt + CNT_W'(1);
                    high_cnt   <= high_cnt + {{(CNT_W-1){1'b0}}, line_p1};
                end
            end
        end
    end

    assign duty_r  = g_ch[0].duty_q;
    assign duty_g  = g_ch[1].duty_q;
    assign duty_b  = g_ch[2].duty_q;
    assign valid_r = g_ch[0].valid_q;
    assign valid_g = g_ch[1].valid_q;
    assign valid_b = g_ch[2].valid_q;
    assign err_r   = g_ch[0].err_q;
    assign err_g   = g_ch[1].err_q;
    assign err_b   = g_ch[2].err_q;

endmodule
